// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a two-bit 4-to-1 mux shared by four
// requesters; grants are one-hot, registered, and bounded to HOLD_MAX cycles under contention.

module two_bit_4to1mux (
    input  logic [1:0] u,
    input  logic [1:0] v,
    input  logic [1:0] w,
    input  logic [1:0] x,
    input  logic [1:0] s,
    output logic [1:0] m
);
    always_comb begin
        unique case (s)
            2'b00:   m = u;
            2'b01:   m = v;
            2'b10:   m = w;
            default: m = x;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic [1:0] u,
    input  logic [1:0] v,
    input  logic [1:0] w,
    input  logic [1:0] x,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic [1:0] m,
    output logic       valid
);
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] hold_q, hold_d;

    logic [3:0] others;
    logic [3:0] cand;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       keep;

    // In GRANT the current grantee is masked out, so a hit is always a different index.
    assign others = req & ~gnt_q;

    always_comb begin
        cand  = (state_q == GRANT) ? others : req;
        found = 1'b0;
        win   = s_q;
        idx   = s_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = s_q + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        keep    = req[s_q] && ((hold_q < HOLD_LIM) || (others == '0));
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    s_d     = win;
                    gnt_d   = 4'b0001 << win;
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (keep) begin
                    if (hold_q < HOLD_LIM) begin
                        hold_d = hold_q + 4'd1;
                    end
                end else if (found) begin
                    s_d    = win;
                    gnt_d  = 4'b0001 << win;
                    hold_d = 4'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // s resets to 3 so the first scan after reset starts at requester 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            s_q     <= 2'b11;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign valid = |gnt_q;

    two_bit_4to1mux u_mux (
        .u (u),
        .v (v),
        .w (w),
        .x (x),
        .s (s_q),
        .m (m)
    );
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, early release, idle return,
// single-requester hold with live data, and asynchronous mid-grant reset.

module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req;
    logic [1:0] u, v, w, x;
    logic [3:0] gnt;
    logic [1:0] s;
    logic [1:0] m;
    logic       valid;

    int n_checks = 0;
    int n_pass   = 0;

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .u      (u),
        .v      (v),
        .w      (w),
        .x      (x),
        .gnt    (gnt),
        .s      (s),
        .m      (m),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [3:0] rot [5];

    initial begin
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
        rot[3] = 4'b1000; rot[4] = 4'b0001;

        resetn = 1'b0;
        req    = 4'b1111;
        u = 2'b00; v = 2'b01; w = 2'b10; x = 2'b11;
        repeat (2) @(negedge clk);
        check_eq("rst_gnt",   gnt,            4'b0000);
        check_eq("rst_valid", {3'b0, valid},  4'b0000);
        check_eq("rst_s",     {2'b0, s},      4'b0011);
        check_eq("rst_m",     {2'b0, m},      4'b0011);
        resetn = 1'b1;

        // Full contention: each grant lasts exactly HOLD_MAX cycles.
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check_eq("rot_gnt",   gnt,           rot[g]);
                check_eq("rot_m",     {2'b0, m},     4'(g % 4));
                check_eq("rot_valid", {3'b0, valid}, 4'b0001);
            end
        end

        req = 4'b0000;
        @(negedge clk);
        check_eq("idle0_gnt",   gnt,           4'b0000);
        check_eq("idle0_valid", {3'b0, valid}, 4'b0000);
        check_eq("idle0_s",     {2'b0, s},     4'b0000);

        req = 4'b0001;
        @(negedge clk);
        check_eq("er_g0a", gnt, 4'b0001);
        @(negedge clk);
        check_eq("er_g0b", gnt, 4'b0001);

        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("er_gnt1",   gnt,           4'b0010);
            check_eq("er_valid",  {3'b0, valid}, 4'b0001);
        end
        @(negedge clk);
        check_eq("er_gnt3", gnt, 4'b1000);

        req = 4'b0100;
        w   = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("sgl_gnt",   gnt,           4'b0100);
            check_eq("sgl_valid", {3'b0, valid}, 4'b0001);
            check_eq("sgl_m",     {2'b0, m},     {2'b0, w});
            w = (w == 2'b01) ? 2'b10 : 2'b01;
            #1;
            check_eq("sgl_m_comb", {2'b0, m}, {2'b0, w});
        end

        req = 4'b0000;
        @(negedge clk);
        check_eq("idle2_gnt",   gnt,           4'b0000);
        check_eq("idle2_valid", {3'b0, valid}, 4'b0000);
        check_eq("idle2_s",     {2'b0, s},     4'b0010);
        check_eq("idle2_m",     {2'b0, m},     {2'b0, w});

        // Pointer at 2: scan order is 3, 0, 1, 2.
        req = 4'b0101;
        @(negedge clk);
        check_eq("ptr_gnt", gnt,       4'b0001);
        check_eq("ptr_s",   {2'b0, s}, 4'b0000);

        req = 4'b1000;
        @(negedge clk);
        check_eq("mr_pre_gnt", gnt,       4'b1000);
        check_eq("mr_pre_s",   {2'b0, s}, 4'b0011);

        resetn = 1'b0;
        #1;
        check_eq("mr_gnt",   gnt,           4'b0000);
        check_eq("mr_valid", {3'b0, valid}, 4'b0000);
        check_eq("mr_s",     {2'b0, s},     4'b0011);
        check_eq("mr_m",     {2'b0, m},     {2'b0, x});
        #2;
        resetn = 1'b1;
        req    = 4'b1001;
        @(negedge clk);
        check_eq("mr_post_gnt", gnt,       4'b0001);
        check_eq("mr_post_s",   {2'b0, s}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
